// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: N-channel push-button conditioner.
// Each channel has a synchroniser, a debounce down-path counter and a
// 4-state FSM. It produces a registered clean level and 1-cycle
// press/release pulses.
// Optional feature macro: AUTOREPEAT_EN. When it is defined, extra press
// pulses are generated while a button stays held.
module btn_debounce_multi #(
  parameter int CHANNELS         = 4,
  parameter int CLK_HZ           = 50_000_000,
  parameter int DEBOUNCE_US      = 10_000,
  parameter int SYNC_STAGES      = 2,
  parameter int REPEAT_DELAY_US  = 500_000,
  parameter int REPEAT_PERIOD_US = 100_000
) (
  input  logic                CLK_50MHZ,
  input  logic                RST_N,
  input  logic [CHANNELS-1:0] BTN_IN,
  output logic [CHANNELS-1:0] BTN_LEVEL,
  output logic [CHANNELS-1:0] BTN_PRESS,
  output logic [CHANNELS-1:0] BTN_RELEASE,
  output logic                BTN_ANY
);

  // state        | meaning
  // IDLE         | debounced level 0, input agrees
  // PRESS_WAIT   | level 0, input has read 1 for cnt cycles
  // HELD         | debounced level 1, input agrees
  // RELEASE_WAIT | level 1, input has read 0 for cnt cycles

  localparam int DB_CYCLES = CLK_HZ / 1_000_000 * DEBOUNCE_US;
  localparam int CNT_W     = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef AUTOREPEAT_EN
  localparam int RPT_DELAY  = CLK_HZ / 1_000_000 * REPEAT_DELAY_US;
  localparam int RPT_PERIOD = CLK_HZ / 1_000_000 * REPEAT_PERIOD_US;
  localparam int RPT_MAX    = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RPT_W      = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(RPT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(RPT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Next-cycle debounced level per channel.
  // BTN_ANY is registered from this signal so that it changes on the
  // same edge as BTN_LEVEL.
  logic [CHANNELS-1:0] level_d;

  if (CHANNELS < 1 || SYNC_STAGES < 2 || DB_CYCLES < 1 ||
      REPEAT_DELAY_US < 0 || REPEAT_PERIOD_US < 0) begin : g_bad_param
    $error("btn_debounce_multi: invalid parameter set");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   cnt_done;
    logic                   level_q;
    logic                   press_q;
    logic                   release_q;
    logic                   rpt_fire;

    assign s        = sync_q[SYNC_STAGES-1];
    assign cnt_done = (cnt_q >= CNT_LAST);

    // Level after this edge.
    // RELEASE_WAIT still reports 1 until the release has been confirmed.
    assign level_d[i] = ((state_q == PRESS_WAIT) && s && cnt_done) ||
                        (state_q == HELD) ||
                        ((state_q == RELEASE_WAIT) && !(!s && cnt_done));

    // Metastability synchroniser for the raw button input.
    always_ff @(posedge CLK_50MHZ) begin
      if (!RST_N) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], BTN_IN[i]};
    end

`ifdef AUTOREPEAT_EN
    logic [RPT_W-1:0] rpt_cnt_q;
    logic             rpt_started_q;

    // The first repeat waits RPT_DELAY cycles. Later repeats wait RPT_PERIOD cycles.
    assign rpt_fire = (state_q == HELD) && s &&
                      (rpt_started_q ? (rpt_cnt_q >= RPT_PERIOD_LAST)
                                     : (rpt_cnt_q >= RPT_DELAY_LAST));

    // Repeat timer.
    // It is held at zero outside a steady HELD, so every entry into HELD starts it fresh.
    always_ff @(posedge CLK_50MHZ) begin
      if (!RST_N || state_q != HELD || !s) begin
        rpt_cnt_q     <= '0;
        rpt_started_q <= 1'b0;
      end else if (rpt_fire) begin
        rpt_cnt_q     <= '0;
        rpt_started_q <= 1'b1;
      end else begin
        rpt_cnt_q     <= rpt_cnt_q + RPT_W'(1);
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Debounce FSM with registered level and pulse outputs.
    always_ff @(posedge CLK_50MHZ) begin
      if (!RST_N) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        level_q   <= level_d[i];
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (s) begin
              state_q <= PRESS_WAIT;
              cnt_q   <= CNT_ONE;
            end
          end
          PRESS_WAIT: begin
            if (!s) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_done) begin
              state_q <= HELD;
              cnt_q   <= '0;
              press_q <= 1'b1;
            end else begin
              cnt_q   <= cnt_q + CNT_ONE;
            end
          end
          HELD: begin
            if (!s) begin
              state_q <= RELEASE_WAIT;
              cnt_q   <= CNT_ONE;
            end else if (rpt_fire) begin
              press_q <= 1'b1;
            end
          end
          RELEASE_WAIT: begin
            if (s) begin
              state_q   <= HELD;
              cnt_q     <= '0;
            end else if (cnt_done) begin
              state_q   <= IDLE;
              cnt_q     <= '0;
              release_q <= 1'b1;
            end else begin
              cnt_q     <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign BTN_LEVEL[i]   = level_q;
    assign BTN_PRESS[i]   = press_q;
    assign BTN_RELEASE[i] = release_q;
  end

  // Any-button flag, registered alongside the per-channel levels.
  always_ff @(posedge CLK_50MHZ) begin
    if (!RST_N) BTN_ANY <= 1'b0;
    else        BTN_ANY <= |level_d;
  end

endmodule
